// File: rtl/i2c_expander_responder.sv
// i2c_expander_responder
//   I2C target emulating a 16-bit PCA9555-style GPIO expander.
//   Register map (pointer 0..7): 0/1 inputs (in_port ^ polarity, read-only),
//   2/3 output regs, 4/5 polarity inversion, 6/7 configuration (1 = input).
// Ports:
//   clk_50, rst_n        : clock, async active-low reset
//   scl_i, sda_i         : bus pin levels (raw, asynchronous)
//   sda_oe               : 1 = pull SDA low (open drain)
//   in_port[15:0]        : expander input pins (asynchronous)
//   port_out[15:0]       : output register value
//   port_dir[15:0]       : configuration register
//   busy                 : address matched, until STOP
//   int_n                : change interrupt, only with I2C_RESP_INT_EN defined
// Optional feature macro: I2C_RESP_INT_EN
module i2c_expander_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h20,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] in_port,
  output logic [15:0] port_out,
  output logic [15:0] port_dir,
  output logic        busy
`ifdef I2C_RESP_INT_EN
  ,
  output logic        int_n
`endif
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // synchronizers, glitch filters, edge history
  logic        scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic        scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
  logic [3:0]  scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic        scl_prev_q, sda_prev_q;
  logic [15:0] in_s1_q, in_s2_q;

  // protocol state
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d, ptr_q, ptr_d;
  logic [7:0]  sh_q, sh_d, tx_q, tx_d;
  logic        rw_q, rw_d, load_q, load_d, busy_q, busy_d, oe_q, oe_d;
  logic [15:0] out_q, out_d, dir_q, dir_d, pol_q, pol_d;

  logic        scl_rise, scl_fall, start, stop, do_load;
  logic [7:0]  rx_byte, rd_byte;

  // Filtered level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    scl_flt_d = scl_flt_q;
    scl_cnt_d = 4'd0;
    if (scl_s2_q != scl_flt_q) begin
      if (scl_cnt_q == 4'(FILTER_LEN - 1)) scl_flt_d = scl_s2_q;
      else                                 scl_cnt_d = scl_cnt_q + 4'd1;
    end
    sda_flt_d = sda_flt_q;
    sda_cnt_d = 4'd0;
    if (sda_s2_q != sda_flt_q) begin
      if (sda_cnt_q == 4'(FILTER_LEN - 1)) sda_flt_d = sda_s2_q;
      else                                 sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  assign scl_rise = scl_flt_q & ~scl_prev_q;
  assign scl_fall = ~scl_flt_q & scl_prev_q;
  assign start    = scl_flt_q & sda_prev_q & ~sda_flt_q;
  assign stop     = scl_flt_q & ~sda_prev_q & sda_flt_q;
  assign rx_byte  = {sh_q[6:0], sda_flt_q};

  always_comb begin
    unique case (ptr_q)
      3'd0:    rd_byte = in_s2_q[7:0]  ^ pol_q[7:0];
      3'd1:    rd_byte = in_s2_q[15:8] ^ pol_q[15:8];
      3'd2:    rd_byte = out_q[7:0];
      3'd3:    rd_byte = out_q[15:8];
      3'd4:    rd_byte = pol_q[7:0];
      3'd5:    rd_byte = pol_q[15:8];
      3'd6:    rd_byte = dir_q[7:0];
      default: rd_byte = dir_q[15:8];
    endcase
  end

  always_comb begin
    state_d = state_q; bit_cnt_d = bit_cnt_q; ptr_d = ptr_q;
    sh_d = sh_q; tx_d = tx_q; rw_d = rw_q; load_d = load_q;
    busy_d = busy_q; oe_d = oe_q;
    out_d = out_q; dir_d = dir_q; pol_d = pol_q;
    do_load = 1'b0;
    if (start) begin
      state_d = ADDR; bit_cnt_d = 3'd0; oe_d = 1'b0; load_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE; bit_cnt_d = 3'd0; oe_d = 1'b0; load_d = 1'b0; busy_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          sh_d = rx_byte; bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK; rw_d = rx_byte[0]; busy_d = 1'b1;
            end else state_d = IGNORE;
          end
        end
        // ACK states: first SCL fall drives ACK, second fall ends it.
        ADDR_ACK: if (scl_fall) begin
          if (!oe_q)     oe_d = 1'b1;
          else if (rw_q) begin do_load = 1'b1; state_d = RD_DATA; end
          else           begin oe_d = 1'b0; state_d = PTR; end
        end
        PTR: if (scl_rise) begin
          sh_d = rx_byte; bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin ptr_d = rx_byte[2:0]; state_d = PTR_ACK; end
        end
        PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else begin oe_d = 1'b0; state_d = WR_DATA; end
        end
        WR_DATA: if (scl_rise) begin
          sh_d = rx_byte; bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            unique case (ptr_q)
              3'd2:    out_d[7:0]  = rx_byte;
              3'd3:    out_d[15:8] = rx_byte;
              3'd4:    pol_d[7:0]  = rx_byte;
              3'd5:    pol_d[15:8] = rx_byte;
              3'd6:    dir_d[7:0]  = rx_byte;
              3'd7:    dir_d[15:8] = rx_byte;
              default: ;  // input registers are read-only
            endcase
            ptr_d   = {ptr_q[2:1], ~ptr_q[0]};
            state_d = WR_ACK;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (load_q) do_load = 1'b1;
            else begin oe_d = ~tx_q[7]; tx_d = {tx_q[6:0], 1'b0}; end
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_fall) oe_d = 1'b0;
          if (scl_rise) begin
            if (!sda_flt_q) begin
              ptr_d = {ptr_q[2:1], ~ptr_q[0]}; load_d = 1'b1; state_d = RD_DATA;
            end else state_d = IGNORE;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
    // byte load: snapshot the register, drive its MSB, keep the rest to shift
    if (do_load) begin
      oe_d = ~rd_byte[7]; tx_d = {rd_byte[6:0], 1'b0};
      load_d = 1'b0; bit_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; sda_s1_q <= 1'b1; sda_s2_q <= 1'b1;
      scl_flt_q <= 1'b1; sda_flt_q <= 1'b1; scl_prev_q <= 1'b1; sda_prev_q <= 1'b1;
      scl_cnt_q <= 4'd0; sda_cnt_q <= 4'd0;
      in_s1_q <= 16'h0; in_s2_q <= 16'h0;
      state_q <= IDLE; bit_cnt_q <= 3'd0; ptr_q <= 3'd0;
      sh_q <= 8'h0; tx_q <= 8'h0; rw_q <= 1'b0; load_q <= 1'b0;
      busy_q <= 1'b0; oe_q <= 1'b0;
      out_q <= 16'hFFFF; dir_q <= 16'hFFFF; pol_q <= 16'h0;
    end else begin
      scl_s1_q <= scl_i; scl_s2_q <= scl_s1_q; sda_s1_q <= sda_i; sda_s2_q <= sda_s1_q;
      scl_flt_q <= scl_flt_d; sda_flt_q <= sda_flt_d;
      scl_prev_q <= scl_flt_q; sda_prev_q <= sda_flt_q;
      scl_cnt_q <= scl_cnt_d; sda_cnt_q <= sda_cnt_d;
      in_s1_q <= in_port; in_s2_q <= in_s1_q;
      state_q <= state_d; bit_cnt_q <= bit_cnt_d; ptr_q <= ptr_d;
      sh_q <= sh_d; tx_q <= tx_d; rw_q <= rw_d; load_q <= load_d;
      busy_q <= busy_d; oe_q <= oe_d;
      out_q <= out_d; dir_q <= dir_d; pol_q <= pol_d;
    end
  end

  assign sda_oe   = oe_q;
  assign busy     = busy_q;
  assign port_out = out_q;
  assign port_dir = dir_q;

`ifdef I2C_RESP_INT_EN
  // Track the raw input value last read through registers 0/1; the
  // interrupt flags any input-configured pin that has moved since.
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]  rd_snap_q, rd_snap_d;
  logic [15:0] last_q, last_d;
  logic        int_n_q, int_n_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q; rd_snap_d = rd_snap_q; last_d = last_q;
    if (do_load) begin
      rd_ptr_d  = ptr_q;
      rd_snap_d = ptr_q[0] ? in_s2_q[15:8] : in_s2_q[7:0];
    end
    if (state_q == RD_ACK && scl_rise && !start && !stop) begin
      if (rd_ptr_q == 3'd0)      last_d[7:0]  = rd_snap_q;
      else if (rd_ptr_q == 3'd1) last_d[15:8] = rd_snap_q;
    end
    int_n_d = ~|((in_s2_q ^ last_d) & dir_q);
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 3'd0; rd_snap_q <= 8'h0; last_q <= 16'h0; int_n_q <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d; rd_snap_q <= rd_snap_d; last_q <= last_d; int_n_q <= int_n_d;
    end
  end

  assign int_n = int_n_q;
`endif

endmodule

// File: tb/tb_i2c_expander_responder.sv
// Directed bench for i2c_expander_responder: a bit-banged I2C master with
// open-drain SDA, checking ACKs, register effects and read data.
module tb_i2c_expander_responder;
  localparam int Q = 20;  // quarter SCL period in clk_50 cycles

  logic        clk_50 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        scl    = 1'b1;
  logic        sda_m  = 1'b1;
  logic [15:0] in_port = 16'h0;
  logic        sda_oe, busy;
  logic [15:0] port_out, port_dir;
`ifdef I2C_RESP_INT_EN
  logic        int_n;
`endif
  wire         sda_line = sda_m & ~sda_oe;

  int checks   = 0;
  int failures = 0;
  int oe_cnt   = 0;

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) if (sda_oe) oe_cnt <= oe_cnt + 1;

  i2c_expander_responder dut (
    .clk_50(clk_50), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .in_port(in_port), .port_out(port_out),
    .port_dir(port_dir), .busy(busy)
`ifdef I2C_RESP_INT_EN
    , .int_n(int_n)
`endif
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(Q); scl = 1'b1; cyc(Q); sda_m = 1'b0; cyc(Q); scl = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(Q); scl = 1'b1; cyc(Q); sda_m = 1'b1; cyc(Q);
  endtask

  // glitch: 2-cycle low pulse on SCL inside the high phase
  task automatic wbit(input logic b, input logic glitch);
    sda_m = b; cyc(Q); scl = 1'b1; cyc(Q);
    if (glitch) begin scl = 1'b0; cyc(2); scl = 1'b1; end
    cyc(Q); scl = 1'b0; cyc(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; cyc(Q); scl = 1'b1; cyc(Q); b = sda_line; cyc(Q); scl = 1'b0; cyc(Q);
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i], 1'b0);
    rbit(a);
    chk(tag, {15'h0, a}, {15'h0, exp_ack});
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(nack, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       a;
    int         oe0;
    logic [7:0] addr_w;

    // reset state
    cyc(5);
    chk("rst_oe", {15'h0, sda_oe}, 16'h0);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_port_out", port_out, 16'hFFFF);
    chk("rst_port_dir", port_dir, 16'hFFFF);
`ifdef I2C_RESP_INT_EN
    chk("rst_int_n", {15'h0, int_n}, 16'h1);
`endif
    rst_n = 1'b1; cyc(10);

    // address mismatch: no ACK, no effect
    oe0 = oe_cnt;
    i2c_start(); send("mm_addr", 8'h42, 1'b1); send("mm_ptr", 8'h02, 1'b1);
    send("mm_data", 8'h55, 1'b1); i2c_stop(); cyc(10);
    chk("mm_oe_cycles", 16'(oe_cnt - oe0), 16'h0);
    chk("mm_port_out", port_out, 16'hFFFF);
    chk("mm_busy", {15'h0, busy}, 16'h0);

    // write both output registers
    i2c_start(); send("wr_addr", 8'h40, 1'b0);
    chk("wr_busy_hi", {15'h0, busy}, 16'h1);
    send("wr_ptr", 8'h02, 1'b0); send("wr_d0", 8'hA5, 1'b0); send("wr_d1", 8'h3C, 1'b0);
    chk("wr_port_out_pre_stop", port_out, 16'h3CA5);
    i2c_stop(); cyc(10);
    chk("wr_busy_lo", {15'h0, busy}, 16'h0);
    chk("wr_port_out", port_out, 16'h3CA5);

    // read inputs with pointer wrap 0 -> 1 -> 0
    in_port = 16'h1234; cyc(5);
    i2c_start(); send("rd_addr_w", 8'h40, 1'b0); send("rd_ptr", 8'h00, 1'b0);
    i2c_start(); send("rd_addr_r", 8'h41, 1'b0);
    rbyte(d, 1'b0); chk("rd_b0", {8'h0, d}, 16'h0034);
    rbyte(d, 1'b0); chk("rd_b1", {8'h0, d}, 16'h0012);
    rbyte(d, 1'b1); chk("rd_b2", {8'h0, d}, 16'h0034);
    i2c_stop();

    // polarity inversion on the low input byte
    i2c_start(); send("pol_addr", 8'h40, 1'b0); send("pol_ptr", 8'h04, 1'b0);
    send("pol_d", 8'hFF, 1'b0); i2c_stop();
    i2c_start(); send("pol_rd_w", 8'h40, 1'b0); send("pol_rd_ptr", 8'h00, 1'b0);
    i2c_start(); send("pol_rd_r", 8'h41, 1'b0);
    rbyte(d, 1'b1); chk("pol_rd_b0", {8'h0, d}, 16'h00CB);
    i2c_stop();
    i2c_start(); send("pol_clr_addr", 8'h40, 1'b0); send("pol_clr_ptr", 8'h04, 1'b0);
    send("pol_clr_d", 8'h00, 1'b0); i2c_stop();

    // aborted byte: 4 data bits then STOP
    i2c_start(); send("ab_addr", 8'h40, 1'b0); send("ab_ptr", 8'h06, 1'b0);
    wbit(1'b1, 1'b0); wbit(1'b0, 1'b0); wbit(1'b1, 1'b0); wbit(1'b0, 1'b0);
    i2c_stop(); cyc(10);
    chk("ab_port_dir", port_dir, 16'hFFFF);
    i2c_start(); send("ab_rd_w", 8'h40, 1'b0); send("ab_rd_ptr", 8'h06, 1'b0);
    i2c_start(); send("ab_rd_r", 8'h41, 1'b0);
    rbyte(d, 1'b1); chk("ab_rd_dir", {8'h0, d}, 16'h00FF);
    i2c_stop();

    // SCL glitch inside the last address bit must not shift an extra bit
    addr_w = 8'h40;
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(addr_w[i], i == 0);
    rbit(a); chk("gl_ack", {15'h0, a}, 16'h0);
    send("gl_ptr", 8'h02, 1'b0); send("gl_d", 8'h5A, 1'b0); i2c_stop(); cyc(10);
    chk("gl_port_out", port_out, 16'h3C5A);

    // reset during the address ACK releases SDA at once
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(addr_w[i], 1'b0);
    sda_m = 1'b1; cyc(Q); scl = 1'b1; cyc(Q);
    chk("ack_oe_driven", {15'h0, sda_oe}, 16'h1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_oe", {15'h0, sda_oe}, 16'h0);
    chk("rst_mid_busy", {15'h0, busy}, 16'h0);
    cyc(Q); rst_n = 1'b1; cyc(Q);
    chk("rst_mid_port_out", port_out, 16'hFFFF);

`ifdef I2C_RESP_INT_EN
    // interrupt on input change, cleared by reading register 0
    in_port = 16'h0000; cyc(10);
    chk("int_idle", {15'h0, int_n}, 16'h1);
    in_port = 16'h0001; cyc(6);
    chk("int_low", {15'h0, int_n}, 16'h0);
    i2c_start(); send("int_rd_w", 8'h40, 1'b0); send("int_rd_ptr", 8'h00, 1'b0);
    i2c_start(); send("int_rd_r", 8'h41, 1'b0);
    rbyte(d, 1'b1); chk("int_rd_b0", {8'h0, d}, 16'h0001);
    chk("int_cleared", {15'h0, int_n}, 16'h1);
    i2c_stop();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
